async_reset_sequencer: RTL



---
 rtl/async_reset_pkg.sv | 21 ++
 rtl/reset_sync.sv | 23 ++
 rtl/async_reset_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/async_reset_pkg.sv
// Shared types and defaults for the staged reset sequencer.
// IDX_W must hold NUM_DOMAINS itself, because the index steps one past the last domain.
package async_reset_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        SW_HOLD = 2'd3
    } state_t;

    localparam int DEF_NUM_DOMAINS = 4;
    localparam int DEF_SYNC_STAGES = 3;
    localparam int DEF_STAGE_DELAY = 16;
    localparam int DEF_CNT_W       = 8;

    function automatic int idx_width(input int num_domains);
        return (num_domains + 1 > 2) ? $clog2(num_domains + 1) : 1;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Deassertion synchronizer for rst_n. Assertion is immediate and asynchronous.
// The output rises SYNC_STAGES edges after rst_n rises; it has no backpressure.
module reset_sync #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    output logic synced
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign synced = chain[SYNC_STAGES-1];

endmodule

// File: rtl/async_reset_sequencer.sv
// Staged reset release: all domains assert together on rst_n or a software request, then release in index order.
// Domain i releases SYNC_STAGES+1+i*STAGE_DELAY edges after rst_n rises. hold stretches release spacing only.
module async_reset_sequencer
    import async_reset_pkg::*;
#(
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STAGE_DELAY = DEF_STAGE_DELAY,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hold,
    input  logic                   sw_rst_req,
    output logic                   sw_rst_ack,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   all_released,
    output logic                   busy
);

    localparam int                     IDX_W    = idx_width(NUM_DOMAINS);
    localparam logic [CNT_W-1:0]       RELOAD   = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [IDX_W-1:0]       IDX_ONE  = IDX_W'(1);
    localparam logic [NUM_DOMAINS-1:0] DOM_ONE  = NUM_DOMAINS'(1);

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_nxt;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         idx_nxt;
    logic [NUM_DOMAINS-1:0]   domain_rst_nxt;
    logic                     armed;
    logic                     armed_nxt;
    logic                     sw_seq;
    logic                     sw_seq_nxt;
    logic                     ack_nxt;
    logic                     synced;

    reset_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_reset_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .synced (synced)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        idx_nxt        = idx;
        domain_rst_nxt = domain_rst;
        // A request must be seen low before it can be honoured again.
        armed_nxt      = armed | ~sw_rst_req;
        sw_seq_nxt     = sw_seq;
        ack_nxt        = 1'b0;

        case (state)
            SYNC: begin
                if (synced) begin
                    domain_rst_nxt[0] = 1'b0;
                    cnt_nxt           = RELOAD;
                    idx_nxt           = IDX_ONE;
                    state_nxt         = (NUM_DOMAINS == 1) ? RUN : RELEASE;
                end
            end
            RELEASE: begin
                if (!hold) begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end else begin
                        domain_rst_nxt = domain_rst & ~(DOM_ONE << idx);
                        idx_nxt        = idx + IDX_ONE;
                        cnt_nxt        = RELOAD;
                        if (idx == LAST_IDX) begin
                            state_nxt  = RUN;
                            ack_nxt    = sw_seq;
                            sw_seq_nxt = 1'b0;
                        end
                    end
                end
            end
            RUN: begin
                if (sw_rst_req && armed) begin
                    domain_rst_nxt = '1;
                    cnt_nxt        = RELOAD;
                    armed_nxt      = 1'b0;
                    sw_seq_nxt     = 1'b1;
                    state_nxt      = SW_HOLD;
                end
            end
            SW_HOLD: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    domain_rst_nxt[0] = 1'b0;
                    idx_nxt           = IDX_ONE;
                    cnt_nxt           = RELOAD;
                    if (NUM_DOMAINS == 1) begin
                        state_nxt  = RUN;
                        ack_nxt    = 1'b1;
                        sw_seq_nxt = 1'b0;
                    end else begin
                        state_nxt  = RELEASE;
                    end
                end
            end
            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

    // Outputs come straight from flops so a short rst_n glitch can never leave a domain half-released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            domain_rst <= '1;
            armed      <= 1'b0;
            sw_seq     <= 1'b0;
            sw_rst_ack <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            domain_rst <= domain_rst_nxt;
            armed      <= armed_nxt;
            sw_seq     <= sw_seq_nxt;
            sw_rst_ack <= ack_nxt;
        end
    end

    assign all_released = ~|domain_rst;
    assign busy         = (state != RUN);

endmodule
